vga_rx_monitor: RTL and testbench



---
 rtl/vga_rx_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: recovers pixel coordinates from sampled VGA signals, checks line/frame timing, declares lock.
// Latency: px_* outputs 1 clk after the sampling tick; lock/error state updates 1 clk after the closing edge.
// No backpressure: the video stream is observed only. Optional frame CRC enabled by macro VGA_RX_CRC_EN.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        px_valid,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [23:0] px_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_crc
);

  localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
  localparam logic [11:0] V_TOTAL_C  = 12'(V_TOTAL);
  localparam logic [11:0] H_ACTIVE_C = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACTIVE_C = 12'(V_ACTIVE);
  localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [11:0] inc12(input logic [11:0] v);
    return (&v) ? v : v + 12'd1;
  endfunction

  function automatic logic [9:0] inc10(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  state_t      state;
  logic [3:0]  good_frames;
  logic        vga_clk_d;
  logic        hs_prev, vs_prev, blank_prev;
  logic [11:0] h_cnt, a_cnt, v_cnt, va_cnt;
  logic        line_x_sat, frame_y_sat, frame_bad_acc;
  logic [9:0]  x_cnt, y_cnt;
  logic        y_first;

  // Tick and edge qualifiers, all evaluated against the previous tick's samples.
  logic tick, hs_fall, vs_fall, blank_rise, act;
  assign tick       = vga_clk & ~vga_clk_d;
  assign hs_fall    = tick & hs_prev & ~vga_hs;
  assign vs_fall    = tick & vs_prev & ~vga_vs;
  assign blank_rise = tick & ~blank_prev & vga_blank_n;
  assign act        = tick & vga_blank_n;

  // Coordinate of the pixel being sampled on this tick.
  logic [9:0] pix_x, y_base, pix_y;
  logic       first_eff, x_sat_now, y_sat_now;
  assign pix_x     = blank_rise ? 10'd0 : x_cnt;
  assign y_base    = vs_fall ? 10'd0 : y_cnt;
  assign first_eff = vs_fall | y_first;
  assign pix_y     = (blank_rise & ~first_eff) ? inc10(y_base) : y_base;
  assign x_sat_now = act & (&pix_x);
  assign y_sat_now = act & (&pix_y);

  // Line closes on hs_fall; this tick already belongs to the next line.
  logic line_has_act, line_bad;
  assign line_has_act = (a_cnt != 12'd0);
  assign line_bad = hs_fall & ((h_cnt != H_TOTAL_C) |
                               (line_has_act & (a_cnt != H_ACTIVE_C)) |
                               blank_rise | line_x_sat);

  // Frame closes on vs_fall, after any line closed on the same tick.
  logic [11:0] va_close;
  logic        frame_bad;
  assign va_close  = (hs_fall & line_has_act) ? inc12(va_cnt) : va_cnt;
  assign frame_bad = frame_bad_acc | line_bad | frame_y_sat | y_sat_now |
                     (v_cnt != V_TOTAL_C) | (va_close != V_ACTIVE_C);

  // Register vga_clk and the previous-tick copies of the sync/blank inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_clk_d  <= 1'b0;
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      blank_prev <= 1'b0;
    end else begin
      vga_clk_d <= vga_clk;
      if (tick) begin
        hs_prev    <= vga_hs;
        vs_prev    <= vga_vs;
        blank_prev <= vga_blank_n;
      end
    end
  end

  // Line and frame measurement counters; h_cnt counts the hs_fall tick as the line's first.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt         <= '0;
      a_cnt         <= '0;
      v_cnt         <= '0;
      va_cnt        <= '0;
      line_x_sat    <= 1'b0;
      frame_y_sat   <= 1'b0;
      frame_bad_acc <= 1'b0;
    end else if (tick) begin
      if (hs_fall) begin
        h_cnt      <= 12'd1;
        a_cnt      <= vga_blank_n ? 12'd1 : 12'd0;
        line_x_sat <= x_sat_now;
      end else begin
        h_cnt <= inc12(h_cnt);
        if (vga_blank_n) a_cnt <= inc12(a_cnt);
        if (x_sat_now) line_x_sat <= 1'b1;
      end
      if (vs_fall) begin
        v_cnt         <= hs_fall ? 12'd1 : 12'd0;
        va_cnt        <= '0;
        frame_bad_acc <= 1'b0;
        frame_y_sat   <= y_sat_now;
      end else begin
        if (hs_fall) v_cnt <= inc12(v_cnt);
        if (hs_fall & line_has_act) va_cnt <= inc12(va_cnt);
        if (line_bad) frame_bad_acc <= 1'b1;
        if (y_sat_now) frame_y_sat <= 1'b1;
      end
    end
  end

  // Column/row trackers; the first blank_rise after vsync is row 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      y_first <= 1'b1;
    end else if (tick) begin
      if (act) x_cnt <= inc10(pix_x);
      y_cnt <= pix_y;
      if (blank_rise)   y_first <= 1'b0;
      else if (vs_fall) y_first <= 1'b1;
    end
  end

  // Registered pixel outputs and frame_start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_rgb      <= '0;
      frame_start <= 1'b0;
    end else begin
      px_valid    <= act;
      frame_start <= vs_fall;
      if (act) begin
        px_x   <= pix_x;
        px_y   <= pix_y;
        px_rgb <= {vga_r, vga_g, vga_b};
      end
    end
  end

  // Lock FSM. err_count counts bad frames seen in MEASURE plus the first bad line/frame in LOCKED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEARCH;
      good_frames <= '0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      err_count   <= '0;
    end else if (tick) begin
      case (state)
        SEARCH: begin
          good_frames <= '0;
          if (vs_fall) state <= MEASURE;
        end
        MEASURE: begin
          if (vs_fall) begin
            if (frame_bad) begin
              good_frames <= '0;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else begin
              good_frames <= good_frames + 4'd1;
              if (good_frames + 4'd1 == LOCK_C) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          if (line_bad | (vs_fall & frame_bad)) begin
            state       <= SEARCH;
            locked      <= 1'b0;
            timing_err  <= 1'b1;
            good_frames <= '0;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc_acc;

  // Running CRC over registered pixels; a pixel coinciding with frame_start belongs to the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= 16'h0000;
    end else if (frame_start) begin
      frame_crc <= crc_acc;
      crc_acc   <= px_valid ? crc_step(16'hFFFF, px_rgb) : 16'hFFFF;
    end else if (px_valid) begin
      crc_acc <= crc_step(crc_acc, px_rgb);
    end
  end
`else
  assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced 8x6 timing (4x3 active) so full frames stay short.
// Each pixel spends 2 clk (vga_clk high one clk, low one clk); outputs are read on the falling clk edge.
// No backpressure on the DUT; the bench only drives video and samples results.
module tb_vga_rx_monitor;
  localparam int HT = 8;
  localparam int HA = 4;
  localparam int VT = 6;
  localparam int VA = 3;
  localparam logic [23:0] RED = 24'hFF0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vga_clk = 1'b0;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic        vga_blank_n = 1'b0;
  logic [7:0]  vga_r = 8'd0, vga_g = 8'd0, vga_b = 8'd0;
  logic        px_valid;
  logic [9:0]  px_x, px_y;
  logic [23:0] px_rgb;
  logic        frame_start, locked, timing_err;
  logic [7:0]  err_count;
  logic [15:0] frame_crc;

  int checks = 0;
  int errors = 0;

  // Snapshots taken inside a frame, compared afterwards against hand-derived values.
  logic        fs_snap, last_v, pre_locked, snap_locked, snap_terr;
  logic [9:0]  last_x, last_y, first_x, first_y;
  logic [23:0] last_rgb;
  logic [7:0]  snap_err;
  logic [15:0] exp_crc;

  int cyc = 0, fs_last = -1, fs_period = 0;

  vga_rx_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .err_count(err_count), .frame_crc(frame_crc)
  );

  always #5 clk = ~clk;

  // Measures the spacing of frame_start pulses in clk cycles.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (frame_start) begin
      if (fs_last >= 0) fs_period = cyc - fs_last;
      fs_last = cyc;
    end
  end

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " px_valid"},    32'(px_valid),    32'd0);
    check({tag, " px_x"},        32'(px_x),        32'd0);
    check({tag, " px_y"},        32'(px_y),        32'd0);
    check({tag, " px_rgb"},      32'(px_rgb),      32'd0);
    check({tag, " frame_start"}, 32'(frame_start), 32'd0);
    check({tag, " locked"},      32'(locked),      32'd0);
    check({tag, " timing_err"},  32'(timing_err),  32'd0);
    check({tag, " err_count"},   32'(err_count),   32'd0);
    check({tag, " frame_crc"},   32'(frame_crc),   32'd0);
  endtask

  // One pixel tick: vga_clk high for one clk then low for one clk; returns when outputs are settled.
  task automatic pix(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
    @(negedge clk);
    vga_hs = hs;
    vga_vs = vs;
    vga_blank_n = bl;
    {vga_r, vga_g, vga_b} = rgb;
    vga_clk = 1'b1;
    @(negedge clk);
    vga_clk = 1'b0;
  endtask

  task automatic pre_line();
    for (int p = 0; p < HT; p++) pix(logic'(p >= 2), 1'b1, 1'b0, 24'd0);
  endtask

  // Frame: vsync low during line 0, hsync low for pixels 0-1, active pixels 2..2+HA-1 of lines 1..n_act.
  task automatic run_frame(input int n_act, input logic [23:0] rgb, input int short_l, input int rst_l);
    logic got_first;
    logic act;
    int   len;
    got_first = 1'b0;
    for (int l = 0; l < VT; l++) begin
      len = (l == short_l) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        act = (l >= 1) && (l <= n_act) && (p >= 2) && (p < 2 + HA);
        pix(logic'(p >= 2), logic'(l != 0), act, rgb);
        if (l == 0 && p == 0) fs_snap = frame_start;
        if (act && !got_first) begin
          got_first = 1'b1;
          first_x = px_x;
          first_y = px_y;
        end
        if (l == n_act && p == 2 + HA - 1) begin
          last_v = px_valid;
          last_x = px_x;
          last_y = px_y;
          last_rgb = px_rgb;
        end
        if (l == short_l && p == len - 1) pre_locked = locked;
        if (l == short_l + 1 && p == 0) begin
          snap_locked = locked;
          snap_terr = timing_err;
          snap_err = err_count;
        end
        if (l == rst_l && p == 4) begin
          @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          check_all_zero("midline_reset");
        end
      end
    end
  endtask

  initial begin
`ifdef VGA_RX_CRC_EN
    exp_crc = 16'hFFFF;
    for (int i = 0; i < HA * VA; i++) exp_crc = ref_crc(exp_crc, RED);
`else
    exp_crc = 16'h0000;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_all_zero("reset");

    // Ideal source: frame A is opened by the first detected vs_fall.
    pre_line();
    run_frame(VA, RED, -1, -1);
    check("fs_pulse_first", 32'(fs_snap), 32'd1);
    check("locked_after_A", 32'(locked), 32'd0);
    check("last_px_valid", 32'(last_v), 32'd1);
    check("last_px_x", 32'(last_x), 32'(HA - 1));
    check("last_px_y", 32'(last_y), 32'(VA - 1));
    check("last_px_rgb", 32'(last_rgb), 32'(RED));

    run_frame(VA, RED, -1, -1);
    check("next_px_x", 32'(first_x), 32'd0);
    check("next_px_y", 32'(first_y), 32'd0);
    check("locked_after_B", 32'(locked), 32'd0);
    check("crc_frame1", 32'(frame_crc), 32'(exp_crc));

    run_frame(VA, RED, -1, -1);
    check("locked_after_C", 32'(locked), 32'd1);
    check("terr_ideal", 32'(timing_err), 32'd0);
    check("errcnt_ideal", 32'(err_count), 32'd0);
    check("fs_period", 32'(fs_period), 32'(2 * HT * VT));
    check("crc_frame2", 32'(frame_crc), 32'(exp_crc));

    // Short line (HT-1 ticks) on line 2 while locked.
    run_frame(VA, RED, 2, -1);
    check("short_pre_locked", 32'(pre_locked), 32'd1);
    check("short_locked_drop", 32'(snap_locked), 32'd0);
    check("short_terr", 32'(snap_terr), 32'd1);
    check("short_errcnt", 32'(snap_err), 32'd1);
    check("crc_frame3", 32'(frame_crc), 32'(exp_crc));

    run_frame(VA, RED, -1, -1);
    run_frame(VA, RED, -1, -1);
    check("relock_not_yet", 32'(locked), 32'd0);
    run_frame(VA, RED, -1, -1);
    check("relock", 32'(locked), 32'd1);
    check("terr_sticky", 32'(timing_err), 32'd1);
    check("errcnt_after_relock", 32'(err_count), 32'd1);

    // Reset mid-line while locked.
    run_frame(VA, RED, -1, 2);
    check("after_reset_frame_locked", 32'(locked), 32'd0);
    run_frame(VA, RED, -1, -1);
    run_frame(VA, RED, -1, -1);
    check("post_reset_not_yet", 32'(locked), 32'd0);
    run_frame(VA, RED, -1, -1);
    check("post_reset_relock", 32'(locked), 32'd1);
    check("post_reset_errcnt", 32'(err_count), 32'd0);
    check("post_reset_terr", 32'(timing_err), 32'd0);

    // Frames with one extra active line.
    for (int n = 1; n <= 300; n++) begin
      run_frame(VA + 1, RED, -1, -1);
      if (n == 2) begin
        check("extra_line_errcnt", 32'(err_count), 32'd1);
        check("extra_line_terr", 32'(timing_err), 32'd1);
        check("extra_line_locked", 32'(locked), 32'd0);
      end
    end
    run_frame(VA, RED, -1, -1);
    check("errcnt_saturated", 32'(err_count), 32'd255);
    check("terr_final", 32'(timing_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
